// File: rtl/rr_sel_arbiter_pkg.sv
// Shared definitions for the round-robin select arbiter feeding the 3-to-8 decoder.
package rr_sel_arbiter_pkg;

  localparam int NREQ             = 8;
  localparam int SELW             = 3;
  localparam int HOLD_MAX_DEFAULT = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } state_t;

endpackage

// File: rtl/rr_sel_arbiter_pick.sv
// Combinational priority rotator: first requester at or after ptr, wrapping 7->0.
module rr_pick
  import rr_sel_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] req_i,
  input  logic [SELW-1:0] ptr_i,
  output logic [SELW-1:0] winner_o,
  output logic            any_req_o
);

  logic            found_s;
  logic [SELW-1:0] idx_s;

  // Scan requesters starting at ptr; modulo-8 wrap comes from the 3-bit index.
  always_comb begin
    winner_o = {SELW{1'b0}};
    found_s  = 1'b0;
    idx_s    = {SELW{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      idx_s = ptr_i + SELW'(k);
      if (!found_s && req_i[idx_s]) begin
        winner_o = idx_s;
        found_s  = 1'b1;
      end else begin
        winner_o = winner_o;
      end
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter with hold limit and a one-cycle enable-low gap between grants.
module rr_sel_arbiter
  import rr_sel_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_i,
  input  logic            release_i,
  output logic [SELW-1:0] sel_o,
  output logic            en_o,
  output logic            busy_o,
  output logic            timeout_o
);

  localparam int             HW       = $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0]  HOLD_LIM = HW'(HOLD_MAX);

  state_t          state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            en_q, en_d;
  logic            busy_q, busy_d;
  logic            timeout_q, timeout_d;
  logic [SELW-1:0] winner_s;
  logic            any_req_s;

  rr_pick u_pick (
    .req_i     (req_i),
    .ptr_i     (ptr_q),
    .winner_o  (winner_s),
    .any_req_o (any_req_s)
  );

  // Next-state and registered-output decode; enable/busy follow the next state.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE, GAP: begin
        if (any_req_s) begin
          state_d = GRANT;
          sel_d   = winner_s;
          hold_d  = HW'(1);
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        // Release or withdrawal takes priority over the hold limit.
        if (release_i || !req_i[sel_q]) begin
          state_d = GAP;
          ptr_d   = sel_q + SELW'(1);
        end else if (hold_q == HOLD_LIM) begin
          state_d   = GAP;
          ptr_d     = sel_q + SELW'(1);
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    en_d   = (state_d == GRANT);
    busy_d = (state_d != IDLE);
  end

  // State, pointer, hold counter and output registers; reset drops en at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= {SELW{1'b0}};
      ptr_q     <= {SELW{1'b0}};
      hold_q    <= {HW{1'b0}};
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign sel_o     = sel_q;
  assign en_o      = en_q;
  assign busy_o    = busy_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Self-checking bench for rr_sel_arbiter: directed scenarios plus random traffic
// compared against a behavioural round-robin model.
module tb_rr_sel_arbiter;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       rel;
  logic [2:0] sel;
  logic       en;
  logic       busy;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0 idle, 1 granting, 2 gap.
  int m_mode, m_sel, m_ptr, m_cnt, m_to;

  rr_sel_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req),
    .release_i (rel),
    .sel_o     (sel),
    .en_o      (en),
    .busy_o    (busy),
    .timeout_o (timeout)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_sel = 0; m_ptr = 0; m_cnt = 0; m_to = 0;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else begin
      m_to = 0;
      if (m_mode == 1) begin
        if (rel || !req[m_sel]) begin
          m_mode = 2; m_ptr = (m_sel + 1) % 8;
        end else if (m_cnt == HOLD) begin
          m_mode = 2; m_ptr = (m_sel + 1) % 8; m_to = 1;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end else if (req != 8'h00) begin
        m_mode = 1; m_sel = pick(req, m_ptr); m_cnt = 1;
      end else begin
        m_mode = 0;
      end
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("sel", int'(sel), m_sel);
    check("en", int'(en), (m_mode == 1) ? 1 : 0);
    check("busy", int'(busy), (m_mode != 0) ? 1 : 0);
    check("timeout", int'(timeout), m_to);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'($urandom);
    rel   = 1'b0;
    model_reset();

    // Reset with random requests: all outputs zero.
    #2;
    check("rst_sel", int'(sel), 0);
    check("rst_en", int'(en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_timeout", int'(timeout), 0);
    @(posedge clk); #1;
    check("rst_hold_en", int'(en), 0);
    req = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    step(); step();
    check("idle_en", int'(en), 0);

    // Single requester 5, released in its third enable cycle.
    req = 8'h20;
    step(); check("single_sel", int'(sel), 5); check("single_en1", int'(en), 1);
    step(); check("single_en2", int'(en), 1);
    step(); check("single_en3", int'(en), 1);
    rel = 1'b1;
    step(); check("single_gap_en", int'(en), 0); check("single_gap_busy", int'(busy), 1);
    rel = 1'b0; req = 8'h00;
    step(); check("single_idle_busy", int'(busy), 0);

    // Fairness: everyone requests, release every grant cycle.
    do_reset();
    req = 8'hFF; rel = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step(); check("fair_sel", int'(sel), i % 8); check("fair_en", int'(en), 1);
      step(); check("fair_gap_en", int'(en), 0); check("fair_to", int'(timeout), 0);
    end
    req = 8'h00; rel = 1'b0;
    step(); step();

    // Timeout: requester 2 holds past the limit, then is regranted.
    req = 8'h04;
    for (int i = 0; i < HOLD; i++) begin
      step(); check("to_en", int'(en), 1); check("to_sel", int'(sel), 2);
    end
    step(); check("to_gap_en", int'(en), 0); check("to_pulse", int'(timeout), 1);
    step(); check("to_regrant_sel", int'(sel), 2); check("to_regrant_en", int'(en), 1);
    check("to_pulse_gone", int'(timeout), 0);

    // Withdrawal: requester 3 drops mid-grant.
    req = 8'h00; step(); step();
    req = 8'h08;
    step(); check("wd_sel", int'(sel), 3);
    req = 8'h00;
    step(); check("wd_gap_en", int'(en), 0); check("wd_to", int'(timeout), 0);
    step();

    // Release coinciding with the hold limit: no timeout.
    req = 8'h04;
    for (int i = 0; i < HOLD; i++) step();
    rel = 1'b1;
    step(); check("coll_en", int'(en), 0); check("coll_to", int'(timeout), 0);
    rel = 1'b0; req = 8'h00;
    step(); step();

    // Asynchronous reset in the middle of a grant to requester 6.
    req = 8'h40;
    step(); step();
    check("mid_sel_before", int'(sel), 6);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_en", int'(en), 0);
    check("mid_rst_sel", int'(sel), 0);
    check("mid_rst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(); check("mid_regrant_sel", int'(sel), 6); check("mid_regrant_en", int'(en), 1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom) & 8'($urandom);
      rel = ($urandom_range(0, 4) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
